// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: central game timing for goose-run.
// One shared prescaler produces base ticks. Move and spawn enables are derived
// from the base ticks. The block also runs the game-phase FSM, shortens the
// move period as play continues, and keeps the score.
//
// Handshake note: start, pause and collision are single-cycle pulses with no
// back-pressure. Each pulse is acted on in the cycle it is high, or ignored if
// the current phase does not accept it. move_tick and spawn_tick are one-clock
// registered enables; the consumer must take them in the cycle they are high.
module game_tick_scheduler #(
  parameter int PRESCALE      = 1000000,
  parameter int MOVE_START    = 50,
  parameter int MOVE_MIN      = 10,
  parameter int MOVE_STEP     = 5,
  parameter int SPEEDUP_EVERY = 8,
  parameter int SPAWN_DIV     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        collision,
  output logic        move_tick,
  output logic        spawn_tick,
  output logic        running,
  output logic        game_over,
  output logic [3:0]  level,
  output logic [15:0] score,
  output logic [1:0]  dbg_state
);

  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PERW = $clog2(MOVE_START + 1);
  localparam int SPW  = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam int SDW  = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

  localparam logic [PW-1:0]   PRESC_LAST   = PW'(PRESCALE - 1);
  localparam logic [PERW-1:0] PERIOD_START = PERW'(MOVE_START);
  localparam logic [PERW-1:0] PERIOD_MIN   = PERW'(MOVE_MIN);
  localparam logic [PERW-1:0] PERIOD_STEP  = PERW'(MOVE_STEP);
  localparam logic [SPW-1:0]  SPD_LAST     = SPW'(SPEEDUP_EVERY - 1);
  localparam logic [SDW-1:0]  SPAWN_LAST   = SDW'(SPAWN_DIV - 1);

  // Game-phase encoding, exported on dbg_state.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [PERW-1:0] mcnt_q, mcnt_d;
  logic [PERW-1:0] period_q, period_d;
  logic [SPW-1:0]  spd_q, spd_d;
  logic [SDW-1:0]  spawn_q, spawn_d;
  logic [3:0]      level_q, level_d;
  logic [15:0]     score_q, score_d;
  logic            move_tick_q, move_tick_d;
  logic            spawn_tick_q, spawn_tick_d;
  logic            running_q, running_d;
  logic            game_over_q, game_over_d;

  logic            base_tick;
  logic            period_can_step;
  logic [PERW-1:0] period_last;

  // Base tick is the last prescaler count; only consulted while running.
  assign base_tick   = (presc_q == PRESC_LAST);
  assign period_last = period_q - PERW'(1);
  // One extra bit keeps MIN+STEP from wrapping, so the decrement never underflows.
  assign period_can_step = ({1'b0, period_q} >= ({1'b0, PERIOD_MIN} + {1'b0, PERIOD_STEP}));

  // Next-state logic for the phase FSM and all game counters.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    mcnt_d       = mcnt_q;
    period_d     = period_q;
    spd_d        = spd_q;
    spawn_d      = spawn_q;
    level_d      = level_q;
    score_d      = score_q;
    move_tick_d  = 1'b0;
    spawn_tick_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        presc_d = '0;
        if (start) begin
          // A fresh game always starts from level 0 at the slowest speed.
          state_d  = ST_RUN;
          mcnt_d   = '0;
          period_d = PERIOD_START;
          spd_d    = '0;
          spawn_d  = '0;
          level_d  = '0;
          score_d  = '0;
        end
      end

      ST_RUN: begin
        if (collision) begin
          // Collision beats pause and beats a coincident move event.
          state_d = ST_OVER;
          presc_d = '0;
        end else begin
          if (pause) begin
            state_d = ST_PAUSED;
          end
          if (base_tick) begin
            presc_d = '0;
            if (mcnt_q == period_last) begin
              mcnt_d      = '0;
              move_tick_d = 1'b1;
              if (score_q != 16'hFFFF) begin
                score_d = score_q + 16'd1;
              end
              if (spd_q == SPD_LAST) begin
                spd_d = '0;
                if (period_can_step) begin
                  period_d = period_q - PERIOD_STEP;
                end else begin
                  period_d = PERIOD_MIN;
                end
                if (level_q != 4'hF) begin
                  level_d = level_q + 4'd1;
                end
              end else begin
                spd_d = spd_q + SPW'(1);
              end
              if (spawn_q == SPAWN_LAST) begin
                spawn_d      = '0;
                spawn_tick_d = 1'b1;
              end else begin
                spawn_d = spawn_q + SDW'(1);
              end
            end else begin
              mcnt_d = mcnt_q + PERW'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      ST_PAUSED: begin
        if (pause) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase flags are registered decodes of the next state so they line up with state_q.
  always_comb begin
    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_OVER);
  end

  // State registers with synchronous reset taking priority over every input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      mcnt_q       <= '0;
      period_q     <= PERIOD_START;
      spd_q        <= '0;
      spawn_q      <= '0;
      level_q      <= '0;
      score_q      <= '0;
      move_tick_q  <= 1'b0;
      spawn_tick_q <= 1'b0;
      running_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      mcnt_q       <= mcnt_d;
      period_q     <= period_d;
      spd_q        <= spd_d;
      spawn_q      <= spawn_d;
      level_q      <= level_d;
      score_q      <= score_d;
      move_tick_q  <= move_tick_d;
      spawn_tick_q <= spawn_tick_d;
      running_q    <= running_d;
      game_over_q  <= game_over_d;
    end
  end

  assign move_tick  = move_tick_q;
  assign spawn_tick = spawn_tick_q;
  assign running    = running_q;
  assign game_over  = game_over_q;
  assign level      = level_q;
  assign score      = score_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler with small timing parameters.
// FSM control vectors come from a table; tick timing is checked by a
// scoreboard fed from an independent tick-schedule model.
module tb_game_tick_scheduler;

  localparam int P_PRE   = 4;
  localparam int P_START = 6;
  localparam int P_MIN   = 2;
  localparam int P_STEP  = 2;
  localparam int P_SPD   = 2;
  localparam int P_SPAWN = 3;
  localparam int W       = 53;

  logic        clock;
  logic        reset;
  logic        start;
  logic        pause;
  logic        collision;
  logic        move_tick;
  logic        spawn_tick;
  logic        running;
  logic        game_over;
  logic [3:0]  level;
  logic [15:0] score;
  logic [1:0]  dbg_state;

  game_tick_scheduler #(
    .PRESCALE     (P_PRE),
    .MOVE_START   (P_START),
    .MOVE_MIN     (P_MIN),
    .MOVE_STEP    (P_STEP),
    .SPEEDUP_EVERY(P_SPD),
    .SPAWN_DIV    (P_SPAWN)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .collision (collision),
    .move_tick (move_tick),
    .spawn_tick(spawn_tick),
    .running   (running),
    .game_over (game_over),
    .level     (level),
    .score     (score),
    .dbg_state (dbg_state)
  );

  // Clock / cycle counter
  int cyc = 0;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard state: one record per expected move_tick {cycle, spawn, level, score}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int seen     = 0;
  int last_tick_cyc = 0;

  typedef struct {
    string name;
    logic  st;
    logic  pa;
    logic  co;
    logic  exp_run;
    logic  exp_go;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [W-1:0] pack(input int t, input logic sp, input int lv, input int sc);
    return {32'(t), sp, 4'(lv), 16'(sc)};
  endfunction

  // Independent schedule model: tick n uses period max(START - STEP*((n-1)/SPD), MIN).
  function automatic void push_run(input int t0, input int n_ticks);
    int t;
    int p;
    int lv;
    t = t0 + 1;
    for (int n = 1; n <= n_ticks; n++) begin
      p = P_START - P_STEP * ((n - 1) / P_SPD);
      if (p < P_MIN) p = P_MIN;
      t = t + P_PRE * p;
      lv = n / P_SPD;
      if (lv > 15) lv = 15;
      exp_q.push_back(pack(t, (n % P_SPAWN) == 0, lv, n));
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_ticks(input int target, input int budget);
    int n;
    n = 0;
    while (seen < target && n < budget) begin
      step();
      n++;
    end
    chk("wait_ticks_count", 64'(seen), 64'(target));
  endtask

  // which: 0 = start, 1 = pause, 2 = collision
  task automatic pulse(input int which, output int t);
    t = cyc;
    if (which == 0) start = 1'b1;
    else if (which == 1) pause = 1'b1;
    else collision = 1'b1;
    step();
    start = 1'b0;
    pause = 1'b0;
    collision = 1'b0;
  endtask

  // Scoreboard consumer: pops one expected record per observed move_tick.
  task automatic monitor();
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge clock);
      if (spawn_tick) chk("spawn_with_move", 64'(move_tick), 64'd1);
      if (move_tick) begin
        seen++;
        last_tick_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_move_tick: tick at cycle %0d score %0d, expected none", cyc, score);
        end else begin
          e = exp_q.pop_front();
          a = pack(cyc, spawn_tick, int'(level), int'(score));
          n_checks++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL move_tick_record: got cycle %0d spawn %0d level %0d score %0d, expected cycle %0d spawn %0d level %0d score %0d",
                     a[52:21], a[20], a[19:16], a[15:0], e[52:21], e[20], e[19:16], e[15:0]);
          end
        end
      end
    end
  endtask

  int t;
  int m;
  int x;
  int base;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    collision = 1'b0;

    vecs[0]  = '{"idle_pause_ignored",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"idle_collision_ignored", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"idle_start_pause",       1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"run_start_ignored",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"run_pause",              1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"paused_collision_ign",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"paused_start_ign",       1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"paused_resume",          1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"run_coll_beats_pause",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{"over_pause_ignored",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{"over_collision_ign",     1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{"over_hold",              1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    fork
      monitor();
    join_none

    // Reset and idle
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_outputs", 64'({move_tick, spawn_tick, running, game_over, level, score, dbg_state}), 64'd0);
    repeat (200) step();
    chk("idle_no_ticks", 64'(seen), 64'd0);
    chk("idle_outputs", 64'({move_tick, spawn_tick, running, game_over, level, score}), 64'd0);

    // Table-driven phase control
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].st;
      pause = vecs[i].pa;
      collision = vecs[i].co;
      step();
      start = 1'b0;
      pause = 1'b0;
      collision = 1'b0;
      chk(vecs[i].name, 64'({running, game_over}), 64'({vecs[i].exp_run, vecs[i].exp_go}));
    end
    chk("table_no_ticks", 64'(seen), 64'd0);

    // Long run: speed-up sequence, level saturation, spawn cadence
    base = seen;
    pulse(0, t);
    chk("runA_started", 64'({running, game_over, level, score}), 64'({1'b1, 1'b0, 4'd0, 16'd0}));
    push_run(t, 32);
    wait_ticks(base + 32, 800);
    pulse(2, t);
    chk("runA_over", 64'({running, game_over, level, score}), 64'({1'b0, 1'b1, 4'd15, 16'd32}));

    // Collision after score 5, ignored pulses in game over, restart
    base = seen;
    pulse(0, t);
    push_run(t, 5);
    wait_ticks(base + 5, 300);
    pulse(2, t);
    chk("runB_over", 64'({running, game_over, level, score}), 64'({1'b0, 1'b1, 4'd2, 16'd5}));
    pulse(1, t);
    pulse(2, t);
    repeat (30) step();
    chk("runB_over_no_ticks", 64'(seen), 64'(base + 5));
    chk("runB_over_hold", 64'({running, game_over, level, score}), 64'({1'b0, 1'b1, 4'd2, 16'd5}));
    pulse(0, t);
    chk("restart_cleared", 64'({running, game_over, level, score}), 64'({1'b1, 1'b0, 4'd0, 16'd0}));
    push_run(t, 1);

    // Pause 10 cycles after a move_tick, hold 100 cycles, resume
    wait_ticks(base + 6, 100);
    m = last_tick_cyc;
    wait_until(m + 10);
    pulse(1, t);
    chk("paused_flags", 64'({running, game_over}), 64'd0);
    wait_until(m + 110);
    chk("paused_no_ticks", 64'(seen), 64'(base + 6));
    chk("paused_hold", 64'({level, score}), 64'({4'd0, 16'd1}));
    pulse(1, t);
    exp_q.push_back(pack(t + 14, 1'b0, 1, 2));
    chk("resumed_flags", 64'({running, game_over}), 64'({1'b1, 1'b0}));
    wait_ticks(base + 7, 100);

    // Collision on the exact move-event cycle: period is 4 after level 1
    x = last_tick_cyc;
    wait_until(x + P_PRE * (P_START - P_STEP) - 1);
    pulse(2, t);
    chk("coll_event_over", 64'({running, game_over, level, score}), 64'({1'b0, 1'b1, 4'd1, 16'd2}));
    repeat (10) step();
    chk("coll_event_no_tick", 64'(seen), 64'(base + 7));

    // Reset mid-run with score 7
    base = seen;
    pulse(0, t);
    push_run(t, 7);
    wait_ticks(base + 7, 300);
    chk("runE_score", 64'({level, score}), 64'({4'd3, 16'd7}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun_reset", 64'({move_tick, spawn_tick, running, game_over, level, score, dbg_state}), 64'd0);
    repeat (60) step();
    chk("post_reset_no_ticks", 64'(seen), 64'(base + 7));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
